// File: rtl/scalar_exec_unit.sv
// Pipelined scalar execution unit: registered single-cycle ALU ops plus iterative
// multiply (MUL_BITS_PER_CYCLE bits/iteration) and restoring divide, with valid/ready on both sides.
`ifndef ZERO
`define ZERO 2'b00
`endif
`ifndef POS
`define POS 2'b01
`endif
`ifndef NEG
`define NEG 2'b10
`endif

module scalar_exec_unit #(
    parameter int LEN                = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4:0]     op,
    input  logic [LEN-1:0] rs1,
    input  logic [LEN-1:0] rs2,
    input  logic [LEN-1:0] imm,
    input  logic [LEN-1:0] pc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] result,
    output logic [1:0]     sign_bits,
    output logic           busy
);
    // state    | meaning
    // IDLE     | no op in flight, no result held
    // MUL_ITER | iterating a multiply
    // DIV_ITER | sign-fix, LEN restoring steps, then correction
    // DONE     | result held until consumed
    typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER, DONE} state_t;

    localparam int SW        = $clog2(LEN);
    localparam int CW        = SW + 1;
    localparam int K         = MUL_BITS_PER_CYCLE;
    localparam int MUL_STEPS = LEN / MUL_BITS_PER_CYCLE;

    localparam logic [4:0] OP_MULH = 5'd17;
    localparam logic [4:0] OP_DIV  = 5'd18;
    localparam logic [4:0] OP_DIVU = 5'd19;
    localparam logic [4:0] OP_REM  = 5'd20;
    localparam logic [LEN-1:0] MIN_VAL = {1'b1, {(LEN-1){1'b0}}};

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic               div_fix;
    logic [4:0]         op_q;
    logic               neg_q, neg_r;
    logic [2*LEN-1:0]   acc, mcand;
    logic [LEN-1:0]     opa, opb;

    logic               accept, is_mul, is_div, div_signed, div_zero, div_ovf, div_special;
    logic               load_alu, mul_fin, div_fin, div_sgn_q;
    logic [SW-1:0]      shamt;
    logic [LEN-1:0]     alu_res, mul_res, div_res, res_n;
    logic [2*LEN-1:0]   mul_part, mul_prod;
    logic [LEN:0]       rem_sh, div_diff;

    function automatic logic [LEN-1:0] abs_v(input logic [LEN-1:0] v);
        return v[LEN-1] ? -v : v;
    endfunction

    function automatic logic [1:0] sign_of(input logic [LEN-1:0] v);
        if (v == '0)
            return `ZERO;
        else if (v[LEN-1])
            return `NEG;
        else
            return `POS;
    endfunction

    assign busy      = (state == MUL_ITER) || (state == DIV_ITER);
    assign out_valid = (state == DONE);
    assign in_ready  = ((state == IDLE) || ((state == DONE) && out_ready)) && !flush;
    assign accept    = in_valid && in_ready;

    assign is_mul      = (op == 5'd16) || (op == OP_MULH);
    assign is_div      = (op >= OP_DIV) && (op <= 5'd21);
    assign div_signed  = (op == OP_DIV) || (op == OP_REM);
    assign div_zero    = (rs2 == '0);
    assign div_ovf     = div_signed && (rs1 == MIN_VAL) && (&rs2);
    assign div_special = is_div && (div_zero || div_ovf);
    assign shamt       = rs2[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            5'd0:    alu_res = rs1 + rs2;
            5'd1:    alu_res = rs1 - rs2;
            5'd2:    alu_res = rs1 & rs2;
            5'd3:    alu_res = rs1 | rs2;
            5'd4:    alu_res = rs1 ^ rs2;
            5'd5:    alu_res = rs1 << shamt;
            5'd6:    alu_res = rs1 >> shamt;
            5'd7:    alu_res = $unsigned($signed(rs1) >>> shamt);
            5'd8:    alu_res = LEN'($signed(rs1) < $signed(rs2));
            5'd9:    alu_res = LEN'(rs1 < rs2);
            5'd10:   alu_res = rs1 + imm;
            5'd11:   alu_res = LEN'($signed(rs1) < $signed(imm));
            5'd12:   alu_res = rs1 - rs2;
            5'd13:   alu_res = rs1 + imm;
            5'd14:   alu_res = pc + imm;
            5'd15:   alu_res = imm;
            // Divide corner cases resolve here without iterating.
            5'd18:   alu_res = div_zero ? '1 : MIN_VAL;
            5'd19:   alu_res = '1;
            5'd20:   alu_res = div_zero ? rs1 : '0;
            5'd21:   alu_res = rs1;
            default: alu_res = '0;
        endcase
    end

    assign mul_part = mcand * {{(2*LEN-K){1'b0}}, opb[K-1:0]};
    assign mul_prod = neg_q ? -acc : acc;
    assign mul_res  = (op_q == OP_MULH) ? mul_prod[2*LEN-1:LEN] : mul_prod[LEN-1:0];

    assign div_sgn_q = (op_q == OP_DIV) || (op_q == OP_REM);
    assign rem_sh    = {acc[LEN-1:0], opa[LEN-1]};
    assign div_diff  = rem_sh - {1'b0, opb};
    assign div_res   = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? (neg_q ? -opa : opa)
                                                              : (neg_r ? -acc[LEN-1:0] : acc[LEN-1:0]);

    assign mul_fin = (state == MUL_ITER) && (cnt == '0);
    assign div_fin = (state == DIV_ITER) && !div_fix && (cnt == '0);
    assign res_n   = load_alu ? alu_res : (mul_fin ? mul_res : div_res);

    always_comb begin
        state_n  = state;
        load_alu = 1'b0;
        case (state)
            IDLE:     state_n = IDLE;
            MUL_ITER: if (mul_fin) state_n = DONE;
            DIV_ITER: if (div_fin) state_n = DONE;
            DONE:     if (out_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (accept) begin
            if (is_mul) begin
                state_n = MUL_ITER;
            end else if (is_div && !div_special) begin
                state_n = DIV_ITER;
            end else begin
                state_n  = DONE;
                load_alu = 1'b1;
            end
        end
        if (flush)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            sign_bits <= `ZERO;
            cnt       <= '0;
            div_fix   <= 1'b0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            opa       <= '0;
            opb       <= '0;
        end else begin
            if (load_alu || mul_fin || div_fin) begin
                result    <= res_n;
                sign_bits <= sign_of(res_n);
            end
            if (flush) begin
                cnt     <= '0;
                div_fix <= 1'b0;
            end else if (accept) begin
                op_q <= op;
                if (is_mul) begin
                    acc   <= '0;
                    mcand <= {{LEN{1'b0}}, abs_v(rs1)};
                    opb   <= abs_v(rs2);
                    neg_q <= rs1[LEN-1] ^ rs2[LEN-1];
                    cnt   <= CW'(MUL_STEPS);
                end else if (is_div && !div_special) begin
                    acc     <= '0;
                    opa     <= rs1;
                    opb     <= rs2;
                    neg_q   <= div_signed && (rs1[LEN-1] ^ rs2[LEN-1]);
                    neg_r   <= div_signed && rs1[LEN-1];
                    div_fix <= 1'b1;
                    cnt     <= CW'(LEN);
                end
            end else begin
                case (state)
                    MUL_ITER: begin
                        if (cnt != '0) begin
                            acc   <= acc + mul_part;
                            mcand <= mcand << K;
                            opb   <= opb >> K;
                            cnt   <= cnt - CW'(1);
                        end
                    end
                    DIV_ITER: begin
                        if (div_fix) begin
                            // Divide magnitudes; signs are reapplied in the correction cycle.
                            div_fix <= 1'b0;
                            if (div_sgn_q) begin
                                opa <= abs_v(opa);
                                opb <= abs_v(opb);
                            end
                        end else if (cnt != '0) begin
                            acc <= {{LEN{1'b0}}, (div_diff[LEN] ? rem_sh[LEN-1:0] : div_diff[LEN-1:0])};
                            opa <= {opa[LEN-2:0], ~div_diff[LEN]};
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scalar_exec_unit.sv
// Directed bench for scalar_exec_unit at LEN=32: vector table for single-cycle ops,
// hand-written sequences for iterative ops, backpressure, flush and async reset.
module tb_scalar_exec_unit;
    localparam logic [1:0] S_ZERO = 2'b00;
    localparam logic [1:0] S_POS  = 2'b01;
    localparam logic [1:0] S_NEG  = 2'b10;
    localparam int NV = 24;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  op;
    logic [31:0] rs1, rs2, imm, pc, result;
    logic [1:0]  sign_bits;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] rs1, rs2, imm, pc, res;
        logic [1:0]  sb;
    } vec_t;

    vec_t vecs[NV];

    scalar_exec_unit #(.LEN(32), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs1(rs1), .rs2(rs2), .imm(imm), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sign_bits(sign_bits), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] r, input logic [1:0] s);
        vec_t v;
        v.op = o; v.rs1 = a; v.rs2 = b; v.imm = i; v.pc = p; v.res = r; v.sb = s;
        return v;
    endfunction

    task automatic run_iter(input string name, input logic [4:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int   n;
        logic ok;
        logic got;
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        #1;
        chk({name, " in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        // Requester offers a different request while busy; it must be ignored.
        op = 5'd15; rs1 = 32'h0; rs2 = 32'h0; imm = 32'h55;
        #1;
        ok  = busy && !in_ready && !out_valid;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) got = 1'b1;
            else if (!busy || in_ready) ok = 1'b0;
        end
        in_valid = 1'b0;
        chk({name, " latency"}, n, exp_lat);
        chk({name, " result"}, result, exp_r);
        chk({name, " busy/in_ready while iterating"}, ok, 1);
    endtask

    initial begin
        logic stayed_low;

        vecs[0]  = mk(5'd0,  32'h7FFFFFFF, 32'h1,        0, 0, 32'h80000000, S_NEG);
        vecs[1]  = mk(5'd1,  32'h5,        32'h5,        0, 0, 32'h0,        S_ZERO);
        vecs[2]  = mk(5'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 32'h00F000F0, S_POS);
        vecs[3]  = mk(5'd3,  32'h0F000000, 32'h000000F0, 0, 0, 32'h0F0000F0, S_POS);
        vecs[4]  = mk(5'd4,  32'hFFFFFFFF, 32'h0000FFFF, 0, 0, 32'hFFFF0000, S_NEG);
        vecs[5]  = mk(5'd5,  32'h1,        32'h23,       0, 0, 32'h8,        S_POS);
        vecs[6]  = mk(5'd6,  32'h80000000, 32'h4,        0, 0, 32'h08000000, S_POS);
        vecs[7]  = mk(5'd7,  32'h80000000, 32'h4,        0, 0, 32'hF8000000, S_NEG);
        vecs[8]  = mk(5'd8,  32'hFFFFFFFF, 32'h1,        0, 0, 32'h1,        S_POS);
        vecs[9]  = mk(5'd9,  32'hFFFFFFFF, 32'h1,        0, 0, 32'h0,        S_ZERO);
        vecs[10] = mk(5'd10, 32'hA,        0, 32'hFFFFFFFF, 0, 32'h9,        S_POS);
        vecs[11] = mk(5'd11, 32'hFFFFFFFE, 0, 32'hFFFFFFFF, 0, 32'h1,        S_POS);
        vecs[12] = mk(5'd12, 32'h3,        32'h5,        0, 0, 32'hFFFFFFFE, S_NEG);
        vecs[13] = mk(5'd13, 32'h1000,     0, 32'h20,       0, 32'h1020,     S_POS);
        vecs[14] = mk(5'd14, 0,            0, 32'hFFFFFFFC, 32'h400, 32'h3FC, S_POS);
        vecs[15] = mk(5'd15, 0,            0, 32'hDEADBEEF, 0, 32'hDEADBEEF, S_NEG);
        vecs[16] = mk(5'd18, 32'h5,        32'h0,        0, 0, 32'hFFFFFFFF, S_NEG);
        vecs[17] = mk(5'd19, 32'h5,        32'h0,        0, 0, 32'hFFFFFFFF, S_NEG);
        vecs[18] = mk(5'd21, 32'h9,        32'h0,        0, 0, 32'h9,        S_POS);
        vecs[19] = mk(5'd20, 32'hFFFFFFF9, 32'h0,        0, 0, 32'hFFFFFFF9, S_NEG);
        vecs[20] = mk(5'd18, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h80000000, S_NEG);
        vecs[21] = mk(5'd20, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0,        S_ZERO);
        vecs[22] = mk(5'd22, 32'h5,        32'h5,        0, 0, 32'h0,        S_ZERO);
        vecs[23] = mk(5'd31, 32'h7,        32'h3,        0, 0, 32'h0,        S_ZERO);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rs1 = '0; rs2 = '0; imm = '0; pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset sign_bits", sign_bits, S_ZERO);
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            op = vecs[i].op; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            imm = vecs[i].imm; pc = vecs[i].pc; in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), out_valid, 1);
            chk($sformatf("v%0d result", i), result, vecs[i].res);
            chk($sformatf("v%0d sign_bits", i), sign_bits, vecs[i].sb);
        end

        run_iter("mul -1*-1",     5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        33);
        chk("mul -1*-1 sign_bits", sign_bits, S_POS);
        run_iter("mulh -1*-1",    5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        33);
        chk("mulh -1*-1 sign_bits", sign_bits, S_ZERO);
        run_iter("mul 7*-3",      5'd16, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_iter("mulh 7*-3",     5'd17, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_iter("mulh min*min",  5'd17, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_iter("div -7/2",      5'd18, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34);
        chk("div -7/2 sign_bits", sign_bits, S_NEG);
        run_iter("rem -7/2",      5'd20, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34);
        run_iter("divu 100/7",    5'd19, 32'd100,      32'd7,        32'd14,       34);
        run_iter("remu 100/7",    5'd21, 32'd100,      32'd7,        32'd2,        34);
        run_iter("div 100/-7",    5'd18, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);
        run_iter("rem 100/-7",    5'd20, 32'd100,      32'hFFFFFFF9, 32'd2,        34);

        // Backpressure: ADDI 3+4 held 5 cycles while ADD 1+1 waits at the input.
        @(posedge clk); #1;
        out_ready = 1'b0;
        op = 5'd10; rs1 = 32'd3; rs2 = 32'd0; imm = 32'd4; in_valid = 1'b1;
        #1;
        chk("bp addi in_ready", in_ready, 1);
        @(posedge clk); #1;
        op = 5'd0; rs1 = 32'd1; rs2 = 32'd1; imm = 32'd0;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("bp hold%0d out_valid", j), out_valid, 1);
            chk($sformatf("bp hold%0d result", j), result, 32'd7);
            chk($sformatf("bp hold%0d sign_bits", j), sign_bits, S_POS);
            chk($sformatf("bp hold%0d in_ready", j), in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp back-to-back out_valid", out_valid, 1);
        chk("bp back-to-back result", result, 32'd2);

        // Flush in the tenth cycle of a divide.
        op = 5'd19; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush pre busy", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush busy", busy, 0);
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        stayed_low = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid || busy) stayed_low = 1'b0;
        end
        chk("flush no late result", stayed_low, 1);

        // A request offered during flush must not be accepted.
        flush = 1'b1; in_valid = 1'b1; op = 5'd15; imm = 32'h1234;
        #1;
        chk("flush-cycle in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush-cycle not accepted", out_valid, 0);
        chk("flush keeps result", result, 32'd2);

        // Asynchronous reset in the middle of a multiply.
        op = 5'd16; rs1 = 32'd3; rs2 = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre-reset busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst out_valid", out_valid, 0);
        chk("async rst result", result, 0);
        chk("async rst sign_bits", sign_bits, S_ZERO);
        chk("async rst in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        run_iter("mul after reset", 5'd16, 32'd3, 32'd5, 32'd15, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
